// File: rtl/img_proc_pkg.sv
// Shared op codes and saturating helpers for the pixel stream processor.
// Helpers work on a wide container; callers zero-extend and truncate.
package img_proc_pkg;

    localparam logic [2:0] MODE_PASS = 3'd0;
    localparam logic [2:0] MODE_ADD  = 3'd1;
    localparam logic [2:0] MODE_SUB  = 3'd2;
    localparam logic [2:0] MODE_THR  = 3'd3;
    localparam logic [2:0] MODE_INV  = 3'd4;

    localparam int OP_W = 16;

    function automatic logic [OP_W-1:0] sat_add(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b,
        input logic [OP_W-1:0] maxv
    );
        logic [OP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, maxv}) begin
            return maxv;
        end
        return s[OP_W-1:0];
    endfunction

    function automatic logic [OP_W-1:0] sat_sub(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b
    );
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/img_pixel_op.sv
// Single-channel combinational pixel operator.
// One instance per channel; PIX_W must not exceed OP_W.
module img_pixel_op
    import img_proc_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] sample,
    input  logic [2:0]       mode,
    input  logic [PIX_W-1:0] value,
    input  logic [PIX_W-1:0] thresh,
    output logic [PIX_W-1:0] result
);

    localparam logic [PIX_W-1:0] MAX = '1;

    logic [PIX_W-1:0] add_r;
    logic [PIX_W-1:0] sub_r;

    assign add_r = PIX_W'(sat_add(OP_W'(sample), OP_W'(value), OP_W'(MAX)));
    assign sub_r = PIX_W'(sat_sub(OP_W'(sample), OP_W'(value)));

    always_comb begin
        result = sample;
        case (mode)
            MODE_ADD: result = add_r;
            MODE_SUB: result = sub_r;
            MODE_THR: result = (sample >= thresh) ? MAX : '0;
            MODE_INV: result = MAX - sample;
            default:  result = sample;
        endcase
    end

endmodule

// File: rtl/img_pixel_stream_proc.sv
// Two-stage streaming pixel processor with per-frame config latch,
// pixel counter and end-of-frame tagging over valid/ready.
module img_pixel_stream_proc
    import img_proc_pkg::*;
#(
    parameter  int PIX_W        = 8,
    parameter  int CHANNELS     = 3,
    parameter  int FRAME_PIXELS = 250000,
    localparam int CNT_W        = $clog2(FRAME_PIXELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PIX_W*CHANNELS-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                cfg_mode,
    input  logic [PIX_W-1:0]          cfg_value,
    input  logic [PIX_W-1:0]          cfg_thresh,
    output logic [PIX_W*CHANNELS-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      frame_done,
    output logic [CNT_W-1:0]          pix_count
);

    localparam int DW = PIX_W * CHANNELS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS - 1);

    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_data_q, s1_data_d;
    logic          s1_last_q, s1_last_d;
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_data_q, s2_data_d;
    logic          s2_last_q, s2_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [PIX_W-1:0] value_q, value_d;
    logic [PIX_W-1:0] thresh_q, thresh_d;
    logic             fd_q, fd_d;

    logic          adv;
    logic          accept;
    logic [DW-1:0] op_res;

    assign adv    = out_ready || !s2_valid_q;
    assign accept = in_valid && adv;

    // The cfg latch moves in lockstep with S1, so S2 always sees the
    // config of the frame the S1 beat belongs to.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        img_pixel_op #(
            .PIX_W(PIX_W)
        ) u_op (
            .sample(s1_data_q[c*PIX_W +: PIX_W]),
            .mode  (mode_q),
            .value (value_q),
            .thresh(thresh_q),
            .result(op_res[c*PIX_W +: PIX_W])
        );
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_last_d  = s2_last_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        value_d    = value_q;
        thresh_d   = thresh_q;
        fd_d       = s2_valid_q && out_ready && s2_last_q;

        if (adv) begin
            s1_valid_d = in_valid;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                s2_data_d = op_res;
            end
        end

        if (accept) begin
            s1_data_d = in_data;
            s1_last_d = (cnt_q == CNT_LAST);
            cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == '0) begin
                mode_d   = cfg_mode;
                value_d  = cfg_value;
                thresh_d = cfg_thresh;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
            cnt_q      <= '0;
            mode_q     <= MODE_PASS;
            value_q    <= '0;
            thresh_q   <= '0;
            fd_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_last_q  <= s2_last_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            value_q    <= value_d;
            thresh_q   <= thresh_d;
            fd_q       <= fd_d;
        end
    end

    assign in_ready   = adv;
    assign out_data   = s2_data_q;
    assign out_valid  = s2_valid_q;
    assign out_last   = s2_last_q;
    assign frame_done = fd_q;
    assign pix_count  = cnt_q;

endmodule

// File: tb/tb_img_pixel_stream_proc.sv
// Scoreboard bench for img_pixel_stream_proc with a 4-pixel frame.
// Driver pushes model results; a monitor pops them on each output beat.
module tb_img_pixel_stream_proc;

    localparam int PW = 8;
    localparam int CH = 3;
    localparam int FP = 4;
    localparam int DW = PW * CH;
    localparam int CW = $clog2(FP);

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    cfg_mode;
    logic [PW-1:0] cfg_value;
    logic [PW-1:0] cfg_thresh;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          frame_done;
    logic [CW-1:0] pix_count;

    img_pixel_stream_proc #(
        .PIX_W(PW),
        .CHANNELS(CH),
        .FRAME_PIXELS(FP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cfg_mode(cfg_mode),
        .cfg_value(cfg_value),
        .cfg_thresh(cfg_thresh),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .frame_done(frame_done),
        .pix_count(pix_count)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   model_cnt = 0;
    int   lm = 0;
    int   lv = 0;
    int   lt = 0;
    int   fd_seen = 0;
    bit   rand_bp = 0;
    int   force_stall = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int ref_op(int c, int m, int v, int t);
        case (m)
            1: return (c + v > 255) ? 255 : c + v;
            2: return (c - v < 0) ? 0 : c - v;
            3: return (c >= t) ? 255 : 0;
            4: return 255 - c;
            default: return c;
        endcase
    endfunction

    // Entered and left just after a falling edge.
    task automatic send(input logic [DW-1:0] d);
        int   w;
        exp_t e;
        w = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (model_cnt == 0) begin
            lm = int'(cfg_mode);
            lv = int'(cfg_value);
            lt = int'(cfg_thresh);
        end
        e.last = (model_cnt == FP - 1);
        for (int c = 0; c < CH; c++) begin
            e.d[c*PW +: PW] = 8'(ref_op(int'(d[c*PW +: PW]), lm, lv, lt));
        end
        sb.push_back(e);
        model_cnt = (model_cnt + 1) % FP;
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        chk("pix_count", 64'(pix_count), 64'(model_cnt));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            idle(1);
            w++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic finish_frame();
        while (model_cnt != 0) begin
            send(DW'($urandom));
        end
    endtask

    task automatic directed(input logic [DW-1:0] d, input logic [DW-1:0] exp,
                            input string name);
        send(d);
        idle(1);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk(name, 64'(out_data), 64'(exp));
    endtask

    always @(negedge clk) begin
        if (force_stall > 0) begin
            out_ready = 1'b0;
            force_stall--;
        end else begin
            out_ready = rand_bp ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    logic [DW-1:0] prev_d;
    logic          prev_l;
    logic          prev_stall = 1'b0;
    logic          prev_hs_last = 1'b0;
    exp_t          me;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall   = 1'b0;
            prev_hs_last = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(out_ready || !out_valid));
            chk("frame_done", 64'(frame_done), 64'(prev_hs_last));
            if (frame_done) fd_seen++;
            if (prev_stall) begin
                chk("stall_data", 64'(out_data), 64'(prev_d));
                chk("stall_last", 64'(out_last), 64'(prev_l));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h want none", out_data);
                end else begin
                    me = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(me.d));
                    chk("out_last", 64'(out_last), 64'(me.last));
                end
            end
            prev_stall   = out_valid && !out_ready;
            prev_d       = out_data;
            prev_l       = out_last;
            prev_hs_last = out_valid && out_ready && out_last;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        cfg_mode   = 3'd0;
        cfg_value  = '0;
        cfg_thresh = '0;
        @(negedge clk);
        #1;

        in_valid = 1'b1;
        in_data  = DW'($urandom);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pix_count", 64'(pix_count), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        idle(2);
        chk("post_rst_valid", 64'(out_valid), 64'd0);

        cfg_mode  = 3'd1;
        cfg_value = 8'd60;
        send({8'd195, 8'd10, 8'd200});
        chk("lat1_valid", 64'(out_valid), 64'd0);
        idle(1);
        chk("lat2_valid", 64'(out_valid), 64'd1);
        chk("add_sat", 64'(out_data), 64'({8'd255, 8'd70, 8'd255}));
        finish_frame();
        drain();

        cfg_mode  = 3'd2;
        cfg_value = 8'd60;
        directed({3{8'd50}}, '0, "sub_floor");
        finish_frame();
        drain();
        cfg_mode   = 3'd3;
        cfg_thresh = 8'd120;
        directed({3{8'd119}}, '0, "thr_below");
        directed({3{8'd120}}, {3{8'hff}}, "thr_equal");
        finish_frame();
        drain();
        cfg_mode = 3'd4;
        directed({3{8'h3c}}, {3{8'hc3}}, "invert");
        finish_frame();
        drain();

        cfg_mode = 3'($urandom_range(7));
        for (int i = 0; i < 10; i++) begin
            if (i == 4) force_stall = 3;
            send(DW'($urandom));
        end
        drain();

        finish_frame();
        drain();
        idle(2);
        fd0 = fd_seen;
        for (int i = 0; i < 9; i++) begin
            send(DW'($urandom));
        end
        chk("pix_after9", 64'(pix_count), 64'd1);
        drain();
        idle(2);
        chk("fd_pulses", 64'(fd_seen - fd0), 64'd2);

        finish_frame();
        drain();
        cfg_mode = 3'd0;
        send(DW'($urandom));
        send(DW'($urandom));
        drain();
        cfg_mode = 3'd4;
        directed({3{8'h3c}}, {3{8'h3c}}, "latch_hold");
        send(DW'($urandom));
        drain();
        directed({3{8'h10}}, {3{8'hef}}, "latch_next");
        send(DW'($urandom));
        drain();
        rst_n = 1'b0;
        idle(2);
        rst_n     = 1'b1;
        model_cnt = 0;
        chk("midrst_pix_count", 64'(pix_count), 64'd0);
        cfg_mode  = 3'd1;
        cfg_value = 8'd10;
        directed({8'd250, 8'd5, 8'd100}, {8'd255, 8'd15, 8'd110}, "relatch_add");
        drain();

        rand_bp = 1;
        for (int i = 0; i < 300; i++) begin
            cfg_mode   = 3'($urandom_range(7));
            cfg_value  = 8'($urandom);
            cfg_thresh = 8'($urandom);
            if ($urandom_range(4) == 0) idle(1);
            send(DW'($urandom));
        end
        drain();
        rand_bp = 0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
